// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter/sequencer in front of a 64x8
// single-port memory. Requesters 0 and 1 issue single read/write
// transactions over a level req / one-cycle ack handshake; the arbiter
// serialises them onto the memory's wr/addr/din/dout interface, waits out the
// memory read latency and returns read data to the granted requester.
//
// Handshake: a requester raises reqN with wrN/addrN/wdataN stable and holds
// it until it sees ackN high for one cycle; it drops req in the cycle after
// the ack. The request fields are latched on the grant edge, so a req that
// falls while granted does not abort the transaction. A req still high in
// IDLE after its ack is treated as a new transaction.
//
// Timing (edge E0 = edge on which IDLE samples the request):
//   E0 -> ACCESS (mem_addr/mem_din/mem_wr driven for one cycle)
//   write          : E1 -> ACK, E2 -> IDLE
//   read RD_LAT=0  : E1 captures mem_dout, -> ACK
//   read RD_LAT>0  : E1 -> WAIT, rdata captured on edge E(1+RD_LAT), -> ACK
// The IDLE cycle after ACK is always present.
//
// dbg_state exposes the FSM state (0 IDLE, 1 ACCESS, 2 WAIT, 3 ACK).

module mem_arbiter #(
    parameter int AW     = 6,
    parameter int DW     = 8,
    parameter int RD_LAT = 1    // legal range 0..7
) (
    input  logic          clk,
    input  logic          reset,      // asynchronous, active low
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    // Value loaded into the WAIT down-counter; WAIT ends when it reaches 0.
    localparam int LAT_M1 = (RD_LAT > 0) ? (RD_LAT - 1) : 0;

    state_t        r_state;
    logic          r_grant;       // requester owning the current transaction
    logic          r_last_grant;  // requester served by the last completed transaction
    logic          r_wr;          // latched direction of the current transaction
    logic [2:0]    r_cnt;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_busy;
    logic          r_mem_wr;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_din;
    logic [DW-1:0] r_rdata;

    logic          w_any_req;
    logic          w_win;
    logic          w_win_wr;
    logic [AW-1:0] w_win_addr;
    logic [DW-1:0] w_win_wdata;

    // Winner selection: on a tie the requester that was not served last wins,
    // so a pending loser is always served next; a sole requester always wins.
    always_comb begin
        w_any_req = req0 | req1;
        w_win     = 1'b0;
        if (req0 && req1) begin
            w_win = ~r_last_grant;
        end else if (req1) begin
            w_win = 1'b1;
        end
        w_win_wr    = w_win ? wr1    : wr0;
        w_win_addr  = w_win ? addr1  : addr0;
        w_win_wdata = w_win ? wdata1 : wdata0;
    end

    // Transaction sequencer: grant, drive the memory, wait for read data, ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;   // makes requester 0 win the first tie
            r_wr         <= 1'b0;
            r_cnt        <= 3'd0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    if (w_any_req) begin
                        r_grant    <= w_win;
                        r_wr       <= w_win_wr;
                        r_mem_addr <= w_win_addr;
                        r_mem_din  <= w_win_wdata;
                        r_mem_wr   <= w_win_wr;
                        r_busy     <= 1'b1;
                        r_state    <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    // The memory performs the write on this edge; the enable
                    // is therefore only ever high for the single ACCESS cycle.
                    r_mem_wr <= 1'b0;
                    if (r_wr) begin
                        r_ack0  <= ~r_grant;
                        r_ack1  <= r_grant;
                        r_state <= S_ACK;
                    end else if (RD_LAT == 0) begin
                        r_rdata <= mem_dout;
                        r_ack0  <= ~r_grant;
                        r_ack1  <= r_grant;
                        r_state <= S_ACK;
                    end else begin
                        r_cnt   <= 3'(LAT_M1);
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // mem_addr stays put so the memory pipeline keeps
                    // producing data for this address.
                    if (r_cnt == 3'd0) begin
                        r_rdata <= mem_dout;
                        r_ack0  <= ~r_grant;
                        r_ack1  <= r_grant;
                        r_state <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end

                S_ACK: begin
                    r_ack0       <= 1'b0;
                    r_ack1       <= 1'b0;
                    r_busy       <= 1'b0;
                    r_last_grant <= r_grant;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_ack0   <= 1'b0;
                    r_ack1   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_mem_wr <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. The main instance uses RD_LAT=1; two extra
// instances (RD_LAT=0 and RD_LAT=3) cover the latency sweep. Each instance
// has its own memory model with the matching read pipeline depth.
// Latency is counted in falling edges after the request-sampling rising edge:
// a write ack is seen at the 2nd, a read ack at the (2+RD_LAT)th.

module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy, mem_wr;
  logic [DW-1:0] rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
  logic [1:0]    dbg_state;

  // sweep instances: index 0 -> RD_LAT=0, index 1 -> RD_LAT=3
  logic [1:0]          s_req, s_wr, s_ack0, s_ack1, s_busy, s_mem_wr;
  logic [1:0][AW-1:0]  s_addr, s_mem_addr;
  logic [1:0][DW-1:0]  s_wdata, s_rdata, s_mem_din, s_dout;
  logic [1:0][1:0]     s_dbg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .dbg_state(dbg_state)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(0)) dut_l0 (
    .clk(clk), .reset(reset),
    .req0(s_req[0]), .req1(1'b0), .wr0(s_wr[0]), .wr1(1'b0),
    .addr0(s_addr[0]), .addr1(6'd0), .wdata0(s_wdata[0]), .wdata1(8'd0),
    .ack0(s_ack0[0]), .ack1(s_ack1[0]), .rdata(s_rdata[0]), .busy(s_busy[0]),
    .mem_wr(s_mem_wr[0]), .mem_addr(s_mem_addr[0]), .mem_din(s_mem_din[0]),
    .mem_dout(s_dout[0]), .dbg_state(s_dbg[0])
  );

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) dut_l3 (
    .clk(clk), .reset(reset),
    .req0(s_req[1]), .req1(1'b0), .wr0(s_wr[1]), .wr1(1'b0),
    .addr0(s_addr[1]), .addr1(6'd0), .wdata0(s_wdata[1]), .wdata1(8'd0),
    .ack0(s_ack0[1]), .ack1(s_ack1[1]), .rdata(s_rdata[1]), .busy(s_busy[1]),
    .mem_wr(s_mem_wr[1]), .mem_addr(s_mem_addr[1]), .mem_din(s_mem_din[1]),
    .mem_dout(s_dout[1]), .dbg_state(s_dbg[1])
  );

  // ---------------- memory models ----------------
  logic [DW-1:0] mem_m  [64];
  logic [DW-1:0] mem_s0 [64];
  logic [DW-1:0] mem_s3 [64];
  logic [DW-1:0] m_pipe;
  logic [DW-1:0] p3_1, p3_2, p3_3;

  // one registered read stage (RD_LAT=1)
  always @(posedge clk) begin
    if (mem_wr) mem_m[mem_addr] <= mem_din;
    m_pipe <= mem_m[mem_addr];
  end
  assign mem_dout = m_pipe;

  // combinational read (RD_LAT=0)
  always @(posedge clk) begin
    if (s_mem_wr[0]) mem_s0[s_mem_addr[0]] <= s_mem_din[0];
  end
  assign s_dout[0] = mem_s0[s_mem_addr[0]];

  // three read stages (RD_LAT=3)
  always @(posedge clk) begin
    if (s_mem_wr[1]) mem_s3[s_mem_addr[1]] <= s_mem_din[1];
    p3_1 <= mem_s3[s_mem_addr[1]];
    p3_2 <= p3_1;
    p3_3 <= p3_2;
  end
  assign s_dout[1] = p3_3;

  // ---------------- driver tasks ----------------
  // One transaction on the main instance. Called at a falling edge with the
  // DUT idle; returns at a falling edge with the DUT idle again.
  task automatic do_txn(input int port, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, output int lat, output int other_acks,
                        output int wr_pulses, output logic [AW-1:0] wr_addr,
                        output logic [DW-1:0] wr_data, output int busy_cyc,
                        output logic [DW-1:0] rd, output logic ack_after);
    lat = 0; other_acks = 0; wr_pulses = 0; busy_cyc = 0;
    wr_addr = '0; wr_data = '0; rd = '0;
    if (port == 0) begin
      wr0 = wr; addr0 = addr; wdata0 = wdata; req0 = 1'b1;
    end else begin
      wr1 = wr; addr1 = addr; wdata1 = wdata; req1 = 1'b1;
    end
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (mem_wr) begin
        wr_pulses++;
        wr_addr = mem_addr;
        wr_data = mem_din;
      end
      if ((port == 0) ? ack1 : ack0) other_acks++;
      if ((port == 0) ? ack0 : ack1) begin
        lat = k;
        rd = rdata;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    ack_after = (port == 0) ? ack0 : ack1;
    for (int w = 0; w < 20 && busy; w++) @(negedge clk);
  endtask

  // One requester-0 transaction on a sweep instance.
  task automatic do_s_txn(input int s, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output int lat, output logic [DW-1:0] rd);
    lat = 0;
    rd = '0;
    s_wr[s] = wr; s_addr[s] = addr; s_wdata[s] = wdata; s_req[s] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (s_ack0[s]) begin
        lat = k;
        rd = s_rdata[s];
        break;
      end
    end
    s_req[s] = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 20 && s_busy[s]; w++) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    s_req = '0; s_wr = '0; s_addr = '0; s_wdata = '0;
    repeat (3) @(negedge clk);
    checks++; if ({ack0, ack1, busy, mem_wr} !== 4'b0000) begin failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {ack0, ack1, busy, mem_wr}); end
    checks++; if ({mem_addr, mem_din, rdata} !== 22'd0) begin failures++;
      $display("FAIL reset_data got=%0h exp=0", {mem_addr, mem_din, rdata}); end
    checks++; if (dbg_state !== 2'd0) begin failures++;
      $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    int lat, oth, np, bc; logic [AW-1:0] wa; logic [DW-1:0] wd, rd; logic aa;
    do_txn(0, 1'b1, 6'd24, 8'hC1, lat, oth, np, wa, wd, bc, rd, aa);
    checks++; if (lat !== 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    checks++; if (np !== 1) begin failures++; $display("FAIL wr_pulse_count got=%0d exp=1", np); end
    checks++; if (wa !== 6'd24) begin failures++; $display("FAIL wr_mem_addr got=%0d exp=24", wa); end
    checks++; if (wd !== 8'hC1) begin failures++; $display("FAIL wr_mem_din got=%0h exp=c1", wd); end
    checks++; if (bc !== 2) begin failures++; $display("FAIL wr_busy_cycles got=%0d exp=2", bc); end
    checks++; if (aa !== 1'b0 || oth !== 0) begin failures++;
      $display("FAIL wr_ack_pulse got=%b/%0d exp=0/0", aa, oth); end
    checks++; if (mem_m[24] !== 8'hC1) begin failures++;
      $display("FAIL wr_mem_content got=%0h exp=c1", mem_m[24]); end
  endtask

  task automatic test_readback();
    int lat, oth, np, bc; logic [AW-1:0] wa; logic [DW-1:0] wd, rd; logic aa;
    do_txn(0, 1'b1, 6'd25, 8'h11, lat, oth, np, wa, wd, bc, rd, aa);
    checks++; if (lat !== 2 || wa !== 6'd25) begin failures++;
      $display("FAIL rb_write got=%0d/%0d exp=2/25", lat, wa); end
    do_txn(1, 1'b0, 6'd25, 8'h00, lat, oth, np, wa, wd, bc, rd, aa);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rb_read_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 8'h11) begin failures++; $display("FAIL rb_rdata got=%0h exp=11", rd); end
    checks++; if (oth !== 0) begin failures++; $display("FAIL rb_ack0_quiet got=%0d exp=0", oth); end
    checks++; if (np !== 0 || bc !== 3) begin failures++;
      $display("FAIL rb_read_ctrl got=%0d/%0d exp=0/3", np, bc); end
    do_txn(1, 1'b1, 6'd26, 8'h77, lat, oth, np, wa, wd, bc, rd, aa);
    checks++; if (rdata !== 8'h11) begin failures++;
      $display("FAIL rb_rdata_hold got=%0h exp=11", rdata); end
  endtask

  // Both requesters raise req together; port0 writes, port1 reads the same
  // address. Expected: ack0 at 2, ack1 at 6 (3-cycle spacing + read latency).
  task automatic test_contention();
    int t0, t1, n0; logic [DW-1:0] rd;
    for (int r = 0; r < 4; r++) begin
      t0 = 0; t1 = 0; n0 = 0; rd = '0;
      wr0 = 1'b1; addr0 = 6'(40 + r); wdata0 = 8'(8'hA0 + r);
      wr1 = 1'b0; addr1 = 6'(40 + r);
      req0 = 1'b1; req1 = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (ack0) begin n0++; if (t0 == 0) t0 = k; req0 = 1'b0; end
        if (ack1) begin t1 = k; rd = rdata; req1 = 1'b0; break; end
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      for (int w = 0; w < 20 && busy; w++) @(negedge clk);
      checks++; if (t0 !== 2 || t1 !== 6) begin failures++;
        $display("FAIL contention_order r=%0d got=%0d/%0d exp=2/6", r, t0, t1); end
      checks++; if (n0 !== 1 || rd !== 8'(8'hA0 + r)) begin failures++;
        $display("FAIL contention_data r=%0d got=%0d/%0h exp=1/%0h", r, n0, rd, 8'(8'hA0 + r)); end
    end
  endtask

  // req0 held high throughout; req1 raised once during req0's first access.
  task automatic test_starvation();
    int a0_first, a0_second, t1; logic [DW-1:0] rd;
    a0_first = 0; a0_second = 0; t1 = 0; rd = '0;
    wr0 = 1'b1; addr0 = 6'd50; wdata0 = 8'h3C; req0 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin wr1 = 1'b0; addr1 = 6'd40; req1 = 1'b1; end
      if (ack1) begin t1 = k; rd = rdata; req1 = 1'b0; end
      if (ack0) begin
        if (a0_first == 0) a0_first = k;
        else if (a0_second == 0) a0_second = k;
      end
      if (a0_second != 0) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 20 && busy; w++) @(negedge clk);
    checks++; if (a0_first !== 2 || t1 !== 6 || a0_second !== 9) begin failures++;
      $display("FAIL starvation_order got=%0d/%0d/%0d exp=2/6/9", a0_first, t1, a0_second); end
    checks++; if (rd !== 8'hA0 || mem_m[50] !== 8'h3C) begin failures++;
      $display("FAIL starvation_data got=%0h/%0h exp=a0/3c", rd, mem_m[50]); end
  endtask

  task automatic test_reset_mid_read();
    int lat, oth, np, bc, acks, t0, t1; logic [AW-1:0] wa; logic [DW-1:0] wd, rd; logic aa;
    wr0 = 1'b0; addr0 = 6'd24; wdata0 = 8'h99; req0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if (dbg_state !== 2'd2) begin failures++;
      $display("FAIL rst_pre_state got=%0d exp=2", dbg_state); end
    reset = 1'b0;
    req0 = 1'b0;
    #1;
    checks++; if ({ack0, ack1, busy, mem_wr, dbg_state} !== 6'd0) begin failures++;
      $display("FAIL rst_async_ctrl got=%b exp=000000", {ack0, ack1, busy, mem_wr, dbg_state}); end
    checks++; if ({mem_addr, mem_din, rdata} !== 22'd0) begin failures++;
      $display("FAIL rst_async_data got=%0h exp=0", {mem_addr, mem_din, rdata}); end
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    checks++; if (acks !== 0) begin failures++; $display("FAIL rst_no_ack got=%0d exp=0", acks); end
    // first tie after reset goes to requester 0
    t0 = 0; t1 = 0;
    wr0 = 1'b1; addr0 = 6'd61; wdata0 = 8'h61;
    wr1 = 1'b1; addr1 = 6'd62; wdata1 = 8'h62;
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack0 && t0 == 0) begin t0 = k; req0 = 1'b0; end
      if (ack1) begin t1 = k; req1 = 1'b0; break; end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 20 && busy; w++) @(negedge clk);
    checks++; if (t0 !== 2 || t1 !== 5) begin failures++;
      $display("FAIL rst_first_tie got=%0d/%0d exp=2/5", t0, t1); end
    do_txn(0, 1'b0, 6'd24, 8'h00, lat, oth, np, wa, wd, bc, rd, aa);
    checks++; if (lat !== 3 || rd !== 8'hC1) begin failures++;
      $display("FAIL rst_readback got=%0d/%0h exp=3/c1", lat, rd); end
  endtask

  task automatic test_rdlat_sweep();
    int lat_w, lat_r, exp_r; logic [DW-1:0] rd;
    for (int s = 0; s < 2; s++) begin
      exp_r = (s == 0) ? 2 : 5;
      do_s_txn(s, 1'b1, 6'd7, 8'(8'h5A + s), lat_w, rd);
      do_s_txn(s, 1'b0, 6'd7, 8'h00, lat_r, rd);
      checks++; if (lat_w !== 2) begin failures++;
        $display("FAIL sweep_wr_latency s=%0d got=%0d exp=2", s, lat_w); end
      checks++; if (lat_r !== exp_r) begin failures++;
        $display("FAIL sweep_rd_latency s=%0d got=%0d exp=%0d", s, lat_r, exp_r); end
      checks++; if (rd !== 8'(8'h5A + s)) begin failures++;
        $display("FAIL sweep_rdata s=%0d got=%0h exp=%0h", s, rd, 8'(8'h5A + s)); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_readback();
    test_contention();
    test_starvation();
    test_reset_mid_read();
    test_rdlat_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
